ifetch_responder: RTL and testbench

IFETCH_RESPONDER -- requirements
Module: ifetch_responder

---
 rtl/ifetch_responder.sv | 163 ++++++++++++++++
 tb/tb_ifetch_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// ifetch_responder: one-entry instruction line buffer between the IF stage and a
// simple request/ack backing memory.
// Latency: hit answers combinationally; a miss costs at least 2 cycles
// (request registered on the edge after the miss, fill on the edge of the ack).
// Backpressure: o_stall holds the IF PC and ID register until the line buffer hits.
//
// Ports:
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_addr, i_flush            fetch address from the PC, pipeline redirect
//   o_instr, o_stall           instruction word and stall to the IF stage
//   o_mem_req, o_mem_addr      registered read request to backing memory
//   i_mem_ack, i_mem_rdata     read completion from backing memory
//   o_misaligned               only with IFETCH_MISALIGN_CHK_EN defined
//
// Optional feature: define IFETCH_MISALIGN_CHK_EN to flag fetches with
// i_addr[1:0] != 0 instead of requesting them from memory.

module ifetch_responder #(
    parameter int                 WIDTH    = 32,
    parameter int                 ADDR_W   = 32,
    parameter logic [WIDTH-1:0]   NOP_WORD = WIDTH'(32'h0000_0013)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_flush,
    output logic [WIDTH-1:0]      o_instr,
    output logic                  o_stall,
    output logic                  o_mem_req,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [WIDTH-1:0]      i_mem_rdata
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic                  o_misaligned
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]   buf_tag_q,   buf_tag_d;
    logic [WIDTH-1:0]    buf_data_q,  buf_data_d;
    logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
    logic                mem_req_q,   mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;

    logic                hit;
    logic                misaligned;

    assign hit = buf_valid_q && (buf_tag_q == i_addr);

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misaligned   = (i_addr[1:0] != 2'b00);
    assign o_misaligned = misaligned;
`else
    // Low address bits go to memory untouched in this build.
    assign misaligned   = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State and buffer registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            req_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            req_addr_q  <= req_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        req_addr_d  = req_addr_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            IDLE: begin
                // Any ack seen here has no outstanding request and is ignored.
                if (!hit && !i_flush && !misaligned) begin
                    req_addr_d = i_addr;
                    mem_req_d  = 1'b1;
                    mem_addr_d = i_addr;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (i_mem_ack) begin
                    // A redirect in the ack cycle makes the data stale; the
                    // old buffer contents stay valid.
                    if (!i_flush) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = req_addr_q;
                        buf_data_d  = i_mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (i_flush) begin
                    // Memory still owes us an ack; swallow it in DRAIN rather
                    // than reissuing, so the next request cannot be confused
                    // with the abandoned one.
                    mem_req_d = 1'b0;
                    state_d   = DRAIN;
                end
            end

            DRAIN: begin
                if (i_mem_ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // IF-stage outputs
    // ---------------------------------------------------------------------
    always_comb begin
        o_stall = 1'b1;
        o_instr = NOP_WORD;
        if (misaligned) begin
            // Let the pipeline advance so the exception reaches the trap logic.
            o_stall = 1'b0;
        end else if (hit && (state_q != DRAIN)) begin
            o_stall = 1'b0;
            o_instr = buf_data_q;
        end
    end

    assign o_mem_req  = mem_req_q;
    assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ifetch_responder.sv
module tb_ifetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk;
    logic        i_rstn;
    logic [31:0] i_addr;
    logic        i_flush;
    logic [31:0] o_instr;
    logic        o_stall;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        o_misaligned;
`endif

    ifetch_responder dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_addr      (i_addr),
        .i_flush     (i_flush),
        .o_instr     (o_instr),
        .o_stall     (o_stall),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .o_misaligned(o_misaligned)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic [31:0] instr;
        logic        req;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [31:0] a, input logic f, input logic ak,
                       input logic [31:0] rd, input logic st, input logic [31:0] ins,
                       input logic rq, input logic [31:0] ma);
        vec_t v;
        v.addr = a; v.flush = f; v.ack = ak; v.rdata = rd;
        v.stall = st; v.instr = ins; v.req = rq; v.maddr = ma;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        //  addr        fl ak rdata          | stall instr          req maddr
        // fill at 0x0, ack in the request cycle
        add(32'h0,      0, 0, 32'h0,          1, NOP,           0, 32'h0);
        add(32'h0,      0, 1, 32'hDEADBEEF,   1, NOP,           1, 32'h0);
        add(32'h0,      0, 0, 32'h0,          0, 32'hDEADBEEF,  0, 32'h0);
        // hit hold
        for (int i = 0; i < 4; i++)
            add(32'h0,  0, 0, 32'h0,          0, 32'hDEADBEEF,  0, 32'h0);
        // slow memory at 0x4: 7 cycles without ack
        add(32'h4,      0, 0, 32'h0,          1, NOP,           0, 32'h0);
        for (int i = 0; i < 7; i++)
            add(32'h4,  0, 0, 32'h0,          1, NOP,           1, 32'h4);
        add(32'h4,      0, 1, 32'hCAFE0004,   1, NOP,           1, 32'h4);
        add(32'h4,      0, 0, 32'h0,          0, 32'hCAFE0004,  0, 32'h4);
        // flush during WAIT at 0x8 -> DRAIN, ack 3 cycles later discarded
        add(32'h8,      0, 0, 32'h0,          1, NOP,           0, 32'h4);
        add(32'h8,      1, 0, 32'h0,          1, NOP,           1, 32'h8);
        add(32'h8,      0, 0, 32'h0,          1, NOP,           0, 32'h8);
        add(32'h8,      0, 0, 32'h0,          1, NOP,           0, 32'h8);
        add(32'h8,      0, 1, 32'h00001234,   1, NOP,           0, 32'h8);
        add(32'h4,      0, 0, 32'h0,          0, 32'hCAFE0004,  0, 32'h8);
        add(32'h8,      0, 0, 32'h0,          1, NOP,           0, 32'h8);
        add(32'h8,      0, 1, 32'h88880008,   1, NOP,           1, 32'h8);
        add(32'h8,      0, 0, 32'h0,          0, 32'h88880008,  0, 32'h8);
        // simultaneous flush and ack at 0xC: no fill
        add(32'hC,      0, 0, 32'h0,          1, NOP,           0, 32'h8);
        add(32'hC,      1, 1, 32'hBAD0000C,   1, NOP,           1, 32'hC);
        add(32'h8,      0, 0, 32'h0,          0, 32'h88880008,  0, 32'hC);
        // flush in IDLE: no request
        add(32'hC,      1, 0, 32'h0,          1, NOP,           0, 32'hC);
        add(32'hC,      0, 0, 32'h0,          1, NOP,           0, 32'hC);
        add(32'hC,      0, 1, 32'h0000C0DE,   1, NOP,           1, 32'hC);
        add(32'hC,      0, 0, 32'h0,          0, 32'h0000C0DE,  0, 32'hC);
        // address changes during WAIT: fill uses the requested tag
        add(32'h10,     0, 0, 32'h0,          1, NOP,           0, 32'hC);
        add(32'h14,     0, 0, 32'h0,          1, NOP,           1, 32'h10);
        add(32'h14,     0, 1, 32'h10101010,   1, NOP,           1, 32'h10);
        add(32'h14,     0, 0, 32'h0,          1, NOP,           0, 32'h10);
        add(32'h14,     0, 1, 32'h14141414,   1, NOP,           1, 32'h14);
        add(32'h14,     0, 0, 32'h0,          0, 32'h14141414,  0, 32'h14);
        // stray ack in IDLE is ignored
        add(32'h14,     0, 1, 32'hFFFFFFFF,   0, 32'h14141414,  0, 32'h14);
        add(32'h14,     0, 0, 32'h0,          0, 32'h14141414,  0, 32'h14);
`ifndef IFETCH_MISALIGN_CHK_EN
        // low address bits reach memory unchanged
        add(32'h6,      0, 0, 32'h0,          1, NOP,           0, 32'h14);
        add(32'h6,      0, 1, 32'h00000066,   1, NOP,           1, 32'h6);
        add(32'h6,      0, 0, 32'h0,          0, 32'h00000066,  0, 32'h6);
`else
        add(32'h6,      0, 0, 32'h0,          0, NOP,           0, 32'h14);
        add(32'h6,      0, 0, 32'h0,          0, NOP,           0, 32'h14);
`endif

        // reset state
        i_rstn = 1'b0; i_addr = '0; i_flush = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
        #1;
        check("reset_stall",   {31'd0, o_stall},   32'd1);
        check("reset_instr",   o_instr,            NOP);
        check("reset_mem_req", {31'd0, o_mem_req}, 32'd0);
        check("reset_mem_addr", o_mem_addr,        32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // table: drive at negedge, push expectation, compare 1ns later
        foreach (vecs[k]) begin
            i_addr = vecs[k].addr; i_flush = vecs[k].flush;
            i_mem_ack = vecs[k].ack; i_mem_rdata = vecs[k].rdata;
            sb.push_back(vecs[k]);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_stall", k), {31'd0, o_stall},   {31'd0, e.stall});
            check($sformatf("v%0d_instr", k), o_instr,            e.instr);
            check($sformatf("v%0d_req",   k), {31'd0, o_mem_req}, {31'd0, e.req});
            check($sformatf("v%0d_maddr", k), o_mem_addr,         e.maddr);
`ifdef IFETCH_MISALIGN_CHK_EN
            check($sformatf("v%0d_misal", k), {31'd0, o_misaligned},
                  {31'd0, (e.addr[1:0] != 2'b00)});
`endif
            @(negedge i_clk);
        end

        // reset asserted mid-WAIT abandons the request
        i_addr = 32'h20; i_flush = 1'b0; i_mem_ack = 1'b0;
        @(negedge i_clk);
        #1;
        check("rstwait_req",  {31'd0, o_mem_req}, 32'd1);
        check("rstwait_addr", o_mem_addr,         32'h20);
        i_rstn = 1'b0;
        i_addr = 32'h0;
        #1;
        check("rstwait_req_cleared",  {31'd0, o_mem_req}, 32'd0);
        check("rstwait_addr_cleared", o_mem_addr,         32'h0);
        check("rstwait_stall_tag0",   {31'd0, o_stall},   32'd1);
        check("rstwait_instr_tag0",   o_instr,            NOP);
        @(negedge i_clk);
        // late ack arrives in IDLE after release: ignored, new request issued
        i_rstn = 1'b1; i_addr = 32'h20; i_mem_ack = 1'b1; i_mem_rdata = 32'h55;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        #1;
        check("late_ack_stall", {31'd0, o_stall},   32'd1);
        check("late_ack_req",   {31'd0, o_mem_req}, 32'd1);
        check("late_ack_addr",  o_mem_addr,         32'h20);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h2020;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        #1;
        check("refill_stall", {31'd0, o_stall},   32'd0);
        check("refill_instr", o_instr,            32'h2020);
        check("refill_req",   {31'd0, o_mem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
